// File: rtl/ddr_tx_pkg.sv
// Shared types, constants and the PRBS-8 step for the DDR output pattern transmitter.
package ddr_tx_pkg;

  typedef enum logic [1:0] {IDLE, PRE, BURST, DONE} state_t;

  localparam logic       MODE_CNT  = 1'b0;
  localparam logic       MODE_PRBS = 1'b1;

  // x^8+x^6+x^5+x^4+1: feedback taken from bits 7,5,4,3, shifted in at bit 0
  localparam logic [7:0] PRBS_TAPS = 8'hB8;

  localparam logic       PRE_RISE  = 1'b1;
  localparam logic       PRE_FALL  = 1'b0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/ddr_out_cell.sv
// DDR output register pair: rising beat captured at posedge, falling beat retimed to negedge,
// with clk selecting which one drives the pins.
module ddr_out_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d_rise,
  input  logic [WIDTH-1:0] i_d_fall,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_hold_f;
  logic [WIDTH-1:0] r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise   <= '0;
      r_hold_f <= '0;
    end else begin
      r_rise   <= i_d_rise;
      r_hold_f <= i_d_fall;
    end
  end

  // Falling beat waits half a cycle so it is stable for the whole low phase
  always_ff @(negedge clk or posedge rst) begin
    if (rst) r_fall <= '0;
    else     r_fall <= r_hold_f;
  end

  assign o_q = clk ? r_rise : r_fall;

endmodule

// File: rtl/ddr_output_pattern_tx.sv
// Burst sequencer with counter / PRBS-8 pattern engines feeding a DDR output cell.
// Optional macro DDR_TX_ERR_INJECT_EN adds a single-bit error injector on one falling beat.
module ddr_output_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 8,
  parameter int PRE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [WIDTH-1:0] seed,
`ifdef DDR_TX_ERR_INJECT_EN
  input  logic             err_inj,
  input  logic [LEN_W:0]   err_beat,
`endif
  output logic [WIDTH-1:0] ddr_out,
  output logic             ddr_valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W:0]   beat_cnt
);
  import ddr_tx_pkg::*;

  localparam int PRE_W = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [PRE_W-1:0] r_pre_cnt;
  logic             r_mode;
  logic [LEN_W:0]   r_len;
  logic [LEN_W:0]   r_beat_cnt;
  logic [WIDTH-1:0] r_pat;
  logic [7:0]       r_lfsr;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [7:0]       w_lfsr_rise;
  logic [7:0]       w_lfsr_fall;
  logic [WIDTH-1:0] w_prbs_rise;
  logic [WIDTH-1:0] w_prbs_fall;
  logic [WIDTH-1:0] w_d_rise;
  logic [WIDTH-1:0] w_d_fall;

`ifdef DDR_TX_ERR_INJECT_EN
  logic             r_err_inj;
  logic [LEN_W:0]   r_err_beat;
  logic [LEN_W:0]   w_next_idx;

  // Index of the payload cycle whose beats are being computed at this edge
  assign w_next_idx = (r_state == BURST) ? r_beat_cnt + (LEN_W+1)'(1) : '0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = PRE;
      PRE:     if (r_pre_cnt == PRE_W'(PRE_CYCLES - 1)) w_state_next = BURST;
      BURST:   if (r_beat_cnt == r_len - (LEN_W+1)'(1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_lfsr_rise = lfsr_step(r_lfsr);
  assign w_lfsr_fall = lfsr_step(w_lfsr_rise);

  // Wider buses carry the 8-bit LFSR value replicated
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prbs_rep
      assign w_prbs_rise[gi] = w_lfsr_rise[gi % 8];
      assign w_prbs_fall[gi] = w_lfsr_fall[gi % 8];
    end
  endgenerate

  // Beat pair for the cycle that starts at the coming rising edge
  always_comb begin
    w_d_rise = '0;
    w_d_fall = '0;
    if (w_state_next == PRE) begin
      w_d_rise = {WIDTH{PRE_RISE}};
      w_d_fall = {WIDTH{PRE_FALL}};
    end else if (w_state_next == BURST) begin
      if (r_mode == MODE_CNT) begin
        w_d_rise = r_pat;
        w_d_fall = r_pat + WIDTH'(1);
      end else begin
        w_d_rise = w_prbs_rise;
        w_d_fall = w_prbs_fall;
      end
`ifdef DDR_TX_ERR_INJECT_EN
      if (r_err_inj && (w_next_idx == r_err_beat)) w_d_fall[0] = ~w_d_fall[0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pre_cnt  <= '0;
      r_mode     <= MODE_CNT;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_pat      <= '0;
      r_lfsr     <= 8'h01;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DDR_TX_ERR_INJECT_EN
      r_err_inj  <= 1'b0;
      r_err_beat <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_valid <= (w_state_next == BURST);
      r_busy  <= (w_state_next != IDLE);
      r_done  <= (w_state_next == DONE);
      case (r_state)
        IDLE: if (start) begin
          r_mode     <= mode;
          r_len      <= (burst_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, burst_len};
          r_beat_cnt <= '0;
          r_pre_cnt  <= '0;
          r_pat      <= seed;
          r_lfsr     <= (seed[7:0] == 8'h00) ? 8'h01 : seed[7:0];
`ifdef DDR_TX_ERR_INJECT_EN
          r_err_inj  <= err_inj;
          r_err_beat <= err_beat;
`endif
        end
        PRE:   r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        BURST: if (r_beat_cnt != r_len) r_beat_cnt <= r_beat_cnt + (LEN_W+1)'(1);
        default: ;
      endcase
      if (w_state_next == BURST) begin
        r_pat  <= r_pat + WIDTH'(2);
        r_lfsr <= w_lfsr_fall;
      end
    end
  end

  ddr_out_cell #(.WIDTH(WIDTH)) u_out (
    .clk      (clk),
    .rst      (rst),
    .i_d_rise (w_d_rise),
    .i_d_fall (w_d_fall),
    .o_q      (ddr_out)
  );

  assign ddr_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_ddr_output_pattern_tx.sv
// Randomized bench for ddr_output_pattern_tx against a per-cycle expectation queue built from
// the pattern rules (counter: seed+j, PRBS: walk of a precomputed 255-entry sequence table).
module tb_ddr_output_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic [7:0] seed = 8'd0;
  logic [7:0] ddr_out;
  logic       ddr_valid;
  logic       busy;
  logic       done;
  logic [8:0] beat_cnt;
`ifdef DDR_TX_ERR_INJECT_EN
  logic       err_inj = 1'b0;
  logic [8:0] err_beat = 9'd0;
`endif

  ddr_output_pattern_tx #(.WIDTH(8), .LEN_W(8), .PRE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .burst_len (burst_len),
    .seed      (seed),
`ifdef DDR_TX_ERR_INJECT_EN
    .err_inj   (err_inj),
    .err_beat  (err_beat),
`endif
    .ddr_out   (ddr_out),
    .ddr_valid (ddr_valid),
    .busy      (busy),
    .done      (done),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] f;
    bit         v;
    bit         b;
    bit         d;
    logic [8:0] c;
  } exp_t;

  exp_t       q[$];
  logic [8:0] exp_idle_cnt = 9'd0;
  int         epoch = 0;
  bit         rec = 1'b0;
  logic [7:0] obs[$];
  logic [7:0] prbs_tab[255];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Maximal-length sequence x^8+x^6+x^5+x^4+1 listed from state 0x01
  task automatic build_prbs_tab();
    logic [7:0] s = 8'h01;
    for (int i = 0; i < 255; i++) begin
      prbs_tab[i] = s;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
  endtask

  // Beat j of a burst (rise of cycle k is j=2k, fall is j=2k+1)
  function automatic logic [7:0] model_beat(input bit m, input logic [7:0] sd, input int j);
    logic [7:0] s0;
    int p;
    if (!m) return sd + 8'(j);
    s0 = (sd == 8'h00) ? 8'h01 : sd;
    p = 0;
    for (int i = 0; i < 255; i++) if (prbs_tab[i] == s0) p = i;
    return prbs_tab[(p + 1 + j) % 255];
  endfunction

  initial forever begin : compare
    exp_t e;
    int   ep;
    @(posedge clk); #2;
    if (!rst) begin
      if (q.size() > 0) e = q.pop_front();
      else e = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, exp_idle_cnt};
      ep = epoch;
      chk("rise_beat", {24'd0, ddr_out}, {24'd0, e.r});
      chk("ddr_valid", {31'd0, ddr_valid}, {31'd0, e.v});
      chk("busy", {31'd0, busy}, {31'd0, e.b});
      chk("done", {31'd0, done}, {31'd0, e.d});
      chk("beat_cnt", {23'd0, beat_cnt}, {23'd0, e.c});
      if (rec && e.v) obs.push_back(ddr_out);
      @(negedge clk); #2;
      if (!rst && ep == epoch) begin
        chk("fall_beat", {24'd0, ddr_out}, {24'd0, e.f});
        if (rec && e.v) obs.push_back(ddr_out);
      end
    end
  end

  task automatic push_model(input bit m, input int lf, input logic [7:0] sd,
                            input bit ej, input int eb);
    int n = (lf == 0) ? 256 : lf;
    logic [7:0] f;
    for (int i = 0; i < 2; i++) q.push_back('{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 9'd0});
    for (int k = 0; k < n; k++) begin
      f = model_beat(m, sd, 2*k+1);
      if (ej && eb == k) f[0] = ~f[0];
      q.push_back('{model_beat(m, sd, 2*k), f, 1'b1, 1'b1, 1'b0, 9'(k)});
    end
    q.push_back('{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 9'(n)});
    exp_idle_cnt = 9'(n);
  endtask

  task automatic run_burst(input bit m, input int lf, input logic [7:0] sd,
                           input bit ej, input int eb, input bit poke);
    int n = (lf == 0) ? 256 : lf;
    bit ej_eff = 1'b0;
    @(negedge clk);
    mode = m; burst_len = 8'(lf); seed = sd; start = 1'b1;
`ifdef DDR_TX_ERR_INJECT_EN
    err_inj = ej; err_beat = 9'(eb); ej_eff = ej;
`endif
    push_model(m, lf, sd, ej_eff, eb);
    $display("burst mode=%0d len=%0d seed=%02h inj=%0d@%0d", m, n, sd, ej_eff, eb);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n + 4; i++) begin
      // pulses while busy must be ignored, including with different settings
      if (poke && i < n && (i % 7) == 3) begin
        start = 1'b1; mode = 1'($urandom); seed = 8'($urandom); burst_len = 8'($urandom);
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("idle_after_burst", {31'd0, busy}, 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int bad;
    build_prbs_tab();
    #3;
    chk("rst_ddr_out", {24'd0, ddr_out}, 32'd0);
    chk("rst_valid", {31'd0, ddr_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_beat_cnt", {23'd0, beat_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    obs.delete(); rec = 1'b1;
    run_burst(1'b0, 4, 8'h10, 1'b0, 0, 1'b0);
    rec = 1'b0;
    chk("cnt_first_rise", {24'd0, obs[0]}, 32'h10);
    chk("cnt_first_fall", {24'd0, obs[1]}, 32'h11);
    chk("cnt_last_fall", {24'd0, obs[7]}, 32'h17);
    chk("cnt_valid_beats", obs.size(), 32'd8);

    obs.delete(); rec = 1'b1;
    run_burst(1'b0, 2, 8'hFE, 1'b0, 0, 1'b0);
    rec = 1'b0;
    chk("wrap_ff", {24'd0, obs[1]}, 32'hFF);
    chk("wrap_00", {24'd0, obs[2]}, 32'h00);

    obs.delete(); rec = 1'b1;
    run_burst(1'b1, 0, 8'h00, 1'b0, 0, 1'b0);
    rec = 1'b0;
    chk("prbs_first_rise", {24'd0, obs[0]}, 32'h02);
    chk("prbs_first_fall", {24'd0, obs[1]}, 32'h04);
    bad = 0;
    for (int i = 0; i < 257; i++) if (obs[i] !== obs[i+255]) bad++;
    chk("prbs_period_255", bad, 32'd0);
    bad = 0;
    for (int i = 1; i < 255; i++) if (obs[i] === obs[0]) bad++;
    chk("prbs_no_short_period", bad, 32'd0);

    run_burst(1'b0, 0, 8'h37, 1'b0, 0, 1'b1);

    // Reset in the high phase of payload cycle 2
    @(negedge clk);
    mode = 1'b0; burst_len = 8'd8; seed = 8'h40; start = 1'b1;
    push_model(1'b0, 8, 8'h40, 1'b0, 0);
    $display("burst mode=0 len=8 seed=40 aborted by reset in payload cycle 2");
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1; epoch++; q.delete(); exp_idle_cnt = 9'd0;
    #1;
    chk("midrst_ddr_out", {24'd0, ddr_out}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, ddr_valid}, 32'd0);
    chk("midrst_beat_cnt", {23'd0, beat_cnt}, 32'd0);
    @(posedge clk); #3 rst = 1'b0;

    obs.delete(); rec = 1'b1;
    run_burst(1'b0, 8, 8'h40, 1'b0, 0, 1'b0);
    rec = 1'b0;
    chk("after_rst_first", {24'd0, obs[0]}, 32'h40);
    chk("after_rst_last", {24'd0, obs[15]}, 32'h4F);

`ifdef DDR_TX_ERR_INJECT_EN
    obs.delete(); rec = 1'b1;
    run_burst(1'b0, 4, 8'h00, 1'b1, 1, 1'b0);
    rec = 1'b0;
    chk("inj_fall_c1", {24'd0, obs[3]}, 32'h02);
    chk("inj_rise_c2", {24'd0, obs[4]}, 32'h04);
    run_burst(1'b1, 5, 8'h5A, 1'b1, 5, 1'b0);
`endif

    for (int t = 0; t < 15; t++) begin
      run_burst(1'($urandom), int'($urandom_range(1, 20)), 8'($urandom),
                1'($urandom), int'($urandom_range(0, 20)), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_output_pattern_tx.md
Name: ddr_output_pattern_tx

Overview:
- Transmit-side counterpart of the DDR input throughput test.
- Generates a deterministic data stream and drives it on both clock edges, so the DDR input receiver (on-chip loopback or a second die) can measure throughput and bit errors.
- Sits between the tile's control inputs (ui_in/uio_in) and the output pins (uo_out); pin mapping is done in the top-level wrapper.
- Burst sequencer, two pattern engines (counter and PRBS-8) and a DDR output stage.

Parameters:
- WIDTH, 8, data beat width in bits (pin width).
- LEN_W, 8, burst length field width; a burst is 1..2^LEN_W clock cycles.
- PRE_CYCLES, 2, preamble length in clock cycles.

Ports:
- clk  input  1  single design clock; both edges used by the output stage only.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a burst; sampled on rising clk in IDLE only.
- mode  input  1  0 = counter pattern, 1 = PRBS-8 pattern.
- burst_len  input  LEN_W  burst length in clock cycles; 0 encodes 2^LEN_W.
- seed  input  WIDTH  counter start value or LFSR seed.
- ddr_out  output  WIDTH  DDR data: rising-edge beat while clk=1, falling-edge beat while clk=0.
- ddr_valid  output  1  high for every cycle carrying payload beats (SDR, rising-edge registered).
- busy  output  1  high from the cycle after an accepted start through DONE inclusive.
- done  output  1  one-cycle pulse in the DONE state.
- beat_cnt  output  LEN_W+1  payload cycles sent in the current/last burst.

Behaviour:
- Reset: asynchronous, immediate. ddr_out=0, ddr_valid=0, busy=0, done=0, beat_cnt=0, state=IDLE. Same result when reset is asserted mid-burst; no partial-beat glitch beyond one half-cycle.
- FSM: IDLE -> PRE -> BURST -> DONE -> IDLE, transitions on rising clk.
- IDLE:
  - ddr_out=0.
  - start=1 latches mode, burst_len and seed; clears beat_cnt; goes to PRE.
- PRE:
  - PRE_CYCLES cycles; rising beat = all-ones, falling beat = all-zeros; ddr_valid=0.
  - Gives the receiver an edge for alignment.
- BURST:
  - Lasts N cycles, N = burst_len, or 2^LEN_W when burst_len=0.
  - ddr_valid=1 on every BURST cycle.
  - beat_cnt increments each cycle and saturates at N.
- DONE: 1 cycle; done=1, ddr_out=0, ddr_valid=0.
- start outside IDLE is ignored; there is no queueing.
- Latency: start seen at rising edge T -> busy=1 and PRE from T. First payload rising beat is driven in the high phase of cycle T+PRE_CYCLES.
- Counter mode:
  - Cycle k: rise = seed+2k, fall = seed+2k+1.
  - Arithmetic is mod 2^WIDTH; wraps from 0xFF to 0x00 silently.
- PRBS mode:
  - Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advanced twice per cycle.
  - rise = state after step 1; fall = state after step 2.
  - seed=0 is replaced by 0x01.
  - For WIDTH>8, the beat is the LFSR value replicated.
- DDR stage:
  - Next-cycle pair (r,f) is computed at posedge. r goes to reg_r at posedge; f goes to hold_f at posedge and then to reg_f at negedge.
  - ddr_out = clk ? reg_r : reg_f.
  - The falling beat of cycle k appears in the low phase of cycle k.

Optional Feature:
- Macro: DDR_TX_ERR_INJECT_EN.
- Defined: adds inputs err_inj (1) and err_beat (LEN_W+1). In the next burst, the falling beat of payload cycle err_beat has bit 0 inverted, exactly once per burst.
  - err_inj is latched with start.
  - err_beat >= N injects nothing.
- Undefined: ports absent; stream is always clean.

Decomposition:
- Package ddr_tx_pkg:
  - state enum {IDLE, PRE, BURST, DONE}.
  - MODE_CNT/MODE_PRBS constants.
  - PRBS tap mask 8'hB8.
  - PRE_RISE/PRE_FALL patterns.
  - lfsr_step function.
- Sub-module ddr_out_cell (WIDTH): posedge/negedge registers plus output mux, with async reset. It is isolated so the gate-level and timing checks can target it.

Test Plan:
- Reset, then start with mode=0, seed=0x10, burst_len=4 -> PRE beats FF/00 ×2 cycles, then pairs 10/11, 12/13, 14/15, 16/17. ddr_valid high exactly 4 cycles, done pulses once, beat_cnt=4.
- Counter wrap: seed=0xFE, burst_len=2 -> FE/FF, 00/01.
- PRBS mode, seed=0x00 -> first rise beat is step(0x01). 255 consecutive beats match the reference LFSR model, and the sequence repeats after 255 beats.
- burst_len=0 -> 256 payload cycles; beat_cnt=256. start pulses during the burst are ignored.
- rst asserted in the 3rd payload cycle -> ddr_out=0, busy=0 within the same half-cycle. A new start afterwards yields the full sequence from seed.
- With DDR_TX_ERR_INJECT_EN, err_inj=1, err_beat=1, counter seed=0 -> falling beat of cycle 1 = 0x02 instead of 0x03; all other beats correct.
